color_palette: RTL and testbench

- Parametrised, writable colour palette for the LED character-matrix pipeline.
- Maps a palette index to a multi-channel colour word.
- Adds palette rotation (animated colour cycling), per-read dimming and a 2-stage registered read pipeline.
- Sits between the character/attribute logic and the serial LED driver. It replaces the fixed 16×24 combinational colour table.

---
 rtl/color_palette_pkg.sv | 35 +++
 rtl/color_palette_rotator.sv | 44 ++++
 rtl/color_palette.sv | 158 +++++++++++++++
 tb/tb_color_palette.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/color_palette_pkg.sv
// Shared constants, state type and channel helpers for the colour palette.
package color_palette_pkg;

  localparam int unsigned TABLE_DEPTH = 16;

  // 16-step hue wheel at 0xCC saturation, {ch2, ch1, ch0} = {R, G, B}.
  localparam logic [23:0] DEFAULT_PALETTE [TABLE_DEPTH] = '{
    24'h00CC00, 24'h4CCC00, 24'h99CC00, 24'hCCB200,
    24'hCC6600, 24'hCC1900, 24'hCC0033, 24'hCC007F,
    24'hCC00CC, 24'h7F00CC, 24'h3300CC, 24'h0019CC,
    24'h0066CC, 24'h00B2CC, 24'h00CC99, 24'h00CC4C
  };

  typedef enum logic {
    RELOAD = 1'b0,
    IDLE   = 1'b1
  } palette_state_t;

  function automatic logic [7:0] table_channel(input int unsigned entry,
                                               input int unsigned addr_width,
                                               input int unsigned k);
    logic [3:0]  idx;
    logic [23:0] word;
    idx  = 4'((entry * TABLE_DEPTH) >> addr_width);
    word = DEFAULT_PALETTE[idx];
    return word[(k % 3) * 8 +: 8];
  endfunction

  // Callers zero-extend the channel, so a shift at or past its width yields 0.
  function automatic logic [31:0] dim_channel(input logic [31:0]   value,
                                              input int unsigned shift);
    return (shift >= 32) ? 32'd0 : (value >> shift);
  endfunction

endpackage

// File: rtl/color_palette_rotator.sv
// Palette rotation: a free-running period divider that steps the index offset.
module palette_rotator #(
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned ROT_DIV_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rot_en,
  input  logic [ROT_DIV_WIDTH-1:0] rot_div,
  output logic [ADDR_WIDTH-1:0]    rot_offset
);

  logic [ROT_DIV_WIDTH-1:0] divider_q, divider_d;
  logic [ADDR_WIDTH-1:0]    offset_q, offset_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    divider_d = divider_q;
    offset_d  = offset_q;
    if (rot_en) begin
      if (divider_q == rot_div) begin
        divider_d = '0;
        offset_d  = offset_q + 1'b1;
      end else begin
        // A divider already past a shrunken rot_div wraps through zero.
        divider_d = divider_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignment so all of them sample pre-edge values.
    if (reset) begin
      divider_q <= '0;
      offset_q  <= '0;
    end else begin
      divider_q <= divider_d;
      offset_q  <= offset_d;
    end
  end

  assign rot_offset = offset_q;

endmodule

// File: rtl/color_palette.sv
// Rotating, dimmable colour palette with a 2-stage read pipeline.
// COLOR_PALETTE_WRITE_EN selects a writable RAM reloaded from defaults; otherwise a constant ROM.
module color_palette
  import color_palette_pkg::*;
#(
  parameter int unsigned COLOR_WIDTH   = 8,
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned DIM_WIDTH     = 2,
  parameter int unsigned ROT_DIV_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rd_req,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [DIM_WIDTH-1:0]            dimmer,
  output logic                            rd_valid,
  output logic [CHANNELS*COLOR_WIDTH-1:0] rd_data,
  input  logic                            wr_en,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [CHANNELS*COLOR_WIDTH-1:0] wr_data,
  input  logic                            rot_en,
  input  logic [ROT_DIV_WIDTH-1:0]        rot_div,
  output logic [ADDR_WIDTH-1:0]           rot_offset,
  output logic                            busy
);

  localparam int unsigned DATA_W = CHANNELS * COLOR_WIDTH;
  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;

  function automatic logic [DATA_W-1:0] default_entry(input int unsigned entry);
    logic [DATA_W-1:0] word;
    logic [31:0]       chan;
    word = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      chan = {24'd0, table_channel(entry, ADDR_WIDTH, k)};
      // MSB-align the 8-bit table channel: zero-pad or drop LSBs.
      chan = (COLOR_WIDTH >= 8) ? (chan << (COLOR_WIDTH - 8)) : (chan >> (8 - COLOR_WIDTH));
      word[k*COLOR_WIDTH +: COLOR_WIDTH] = chan[COLOR_WIDTH-1:0];
    end
    return word;
  endfunction

  logic [DATA_W-1:0] default_mem [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_default
    assign default_mem[i] = default_entry(i);
  end

  palette_rotator #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .ROT_DIV_WIDTH(ROT_DIV_WIDTH)
  ) u_rotator (
    .clk       (clk),
    .reset     (reset),
    .rot_en    (rot_en),
    .rot_div   (rot_div),
    .rot_offset(rot_offset)
  );

  logic [ADDR_WIDTH-1:0] ea;
  logic [DATA_W-1:0]     rd_word;

  assign ea = rd_addr + rot_offset;

`ifdef COLOR_PALETTE_WRITE_EN
  palette_state_t        state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     ram [DEPTH];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (state_q == RELOAD) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = default_mem[ptr_q];
      ptr_d     = ptr_q + 1'b1;
      if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = IDLE;
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RELOAD;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: the palette array has no reset; the RELOAD sweep initialises every entry.
  always_ff @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
  end

  // Asynchronous read sampled at the same edge as a write gives read-first behaviour.
  assign rd_word = ram[ea];
  assign busy    = (state_q == RELOAD);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign rd_word   = default_mem[ea];
  assign busy      = 1'b0;
`endif

  logic                 s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]    s1_data_q, s1_data_d;
  logic [DIM_WIDTH-1:0] s1_dim_q, s1_dim_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;

  always_comb begin
    s1_valid_d = rd_req & ~busy;
    s1_data_d  = s1_data_q;
    s1_dim_d   = s1_dim_q;
    if (s1_valid_d) begin
      s1_data_d = rd_word;
      s1_dim_d  = dimmer;
    end
    rd_valid_d = s1_valid_q;
    rd_data_d  = rd_data_q;
    if (s1_valid_q) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        rd_data_d[k*COLOR_WIDTH +: COLOR_WIDTH] = COLOR_WIDTH'(
          dim_channel(32'(s1_data_q[k*COLOR_WIDTH +: COLOR_WIDTH]), 2 * 32'(s1_dim_q)));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_dim_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_dim_q   <= s1_dim_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_color_palette.sv
// Self-checking bench for color_palette: cycle-level reference model plus directed literals.
module tb_color_palette;

`ifdef COLOR_PALETTE_WRITE_EN
  localparam bit WE = 1'b1;
`else
  localparam bit WE = 1'b0;
`endif

  // Hue wheel: hue = 120 - 22.5*i degrees, peak 0xCC, fractional channel truncated.
  localparam logic [23:0] REF_PAL [16] = '{
    24'h00CC00, 24'h4CCC00, 24'h99CC00, 24'hCCB200,
    24'hCC6600, 24'hCC1900, 24'hCC0033, 24'hCC007F,
    24'hCC00CC, 24'h7F00CC, 24'h3300CC, 24'h0019CC,
    24'h0066CC, 24'h00B2CC, 24'h00CC99, 24'h00CC4C
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [1:0]  dimmer = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        rot_en = 1'b0;
  logic [15:0] rot_div = '0;
  logic        rd_valid;
  logic [23:0] rd_data;
  logic [3:0]  rot_offset;
  logic        busy;

  color_palette #(
    .COLOR_WIDTH(8), .CHANNELS(3), .ADDR_WIDTH(4), .DIM_WIDTH(2), .ROT_DIV_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .dimmer(dimmer),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rot_en(rot_en), .rot_div(rot_div), .rot_offset(rot_offset),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic [23:0] val;
  } rd_t;

  logic [23:0] m_mem [16];
  rd_t         pend[$];
  int          m_offset = 0;
  int          m_div = 0;
  int          m_reload = 0;
  int          cyc = 0;
  bit          m_valid = 1'b0;
  logic [23:0] m_data = '0;
  bit          live = 1'b0;

  function automatic logic [23:0] dim_word(input logic [23:0] w, input int d);
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) r |= (((w >> (8 * c)) & 24'hFF) >> (2 * d)) << (8 * c);
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      live     = 1'b1;
      cyc      = 0;
      pend.delete();
      m_valid  = 1'b0;
      m_data   = '0;
      m_offset = 0;
      m_div    = 0;
      m_reload = WE ? 16 : 0;
      for (int i = 0; i < 16; i++) m_mem[i] = REF_PAL[i];
    end else begin
      rd_t e;
      cyc++;
      m_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        m_valid = 1'b1;
        m_data  = pend[0].val;
        void'(pend.pop_front());
      end
      if (rd_req && m_reload == 0) begin
        e.due = cyc + 1;
        e.val = dim_word(m_mem[(int'(rd_addr) + m_offset) % 16], int'(dimmer));
        pend.push_back(e);
      end
      if (WE && wr_en && m_reload == 0) m_mem[wr_addr] = wr_data;
      if (m_reload > 0) m_reload--;
      if (rot_en) begin
        if (m_div == int'(rot_div)) begin
          m_div    = 0;
          m_offset = (m_offset + 1) % 16;
        end else begin
          m_div = (m_div + 1) % 65536;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("busy", 32'(busy), 32'(m_reload > 0));
      check("rot_offset", 32'(rot_offset), 32'(m_offset));
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      check("rd_data", 32'(rd_data), 32'(m_data));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic count_busy(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), WE ? 32'd16 : 32'd0);
  endtask

  task automatic read_lit(input string name, input int addr, input int dim, input logic [23:0] lit);
    rd_req  = 1'b1;
    rd_addr = 4'(addr);
    dimmer  = 2'(dim);
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 32'(rd_valid), 32'd1);
    check(name, 32'(rd_data), 32'(lit));
    check({name, "_model"}, 32'(m_data), 32'(lit));
  endtask

  task automatic wait_offset(input string name, input int target, input int budget);
    int n = 0;
    while (int'(rot_offset) != target && n < budget) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(rot_offset), 32'(target));
  endtask

  initial begin
    @(negedge clk);
    reset = 1'b0;
    count_busy("busy_after_reset");

    read_lit("rd0_d0", 0, 0, 24'h00CC00);
    read_lit("rd8_d1", 8, 1, 24'h330033);
    read_lit("rd8_d3", 8, 3, 24'h030003);
    read_lit("rd3_d2", 3, 2, 24'h0C0B00);
    read_lit("rd15_d0", 15, 0, 24'h00CC4C);

    for (int i = 0; i < 16; i++) begin
      rd_req  = 1'b1;
      rd_addr = 4'(i);
      dimmer  = 2'(i % 4);
      @(negedge clk);
    end
    rd_req = 1'b0;
    repeat (3) @(negedge clk);

    // Write and read of the same entry in one cycle, then a read the next cycle.
    wr_en   = 1'b1;
    wr_addr = 4'd5;
    wr_data = 24'h123456;
    rd_req  = 1'b1;
    rd_addr = 4'd5;
    dimmer  = 2'd0;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    check("wr_read_first", 32'(rd_data), 32'h00CC1900);
    @(negedge clk);
    check("wr_read_next", 32'(rd_data), WE ? 32'h00123456 : 32'h00CC1900);

    rot_div = 16'd3;
    rot_en  = 1'b1;
    wait_offset("rot_reach3", 3, 64);
    read_lit("rot3_rd0", 0, 0, 24'hCCB200);
    wait_offset("rot_reach15", 15, 80);
    wait_offset("rot_wrap0", 0, 8);
    wait_offset("rot_reach5", 5, 40);
    rot_en = 1'b0;
    repeat (10) @(negedge clk);
    check("rot_frozen", 32'(rot_offset), 32'd5);

    rot_div = 16'd0;
    rot_en  = 1'b1;
    repeat (5) @(negedge clk);
    rot_en = 1'b0;
    check("rot_div0_steps", 32'(rot_offset), 32'd10);
    rot_div = 16'd10;
    rot_en  = 1'b1;
    repeat (5) @(negedge clk);
    rot_div = 16'd12;
    for (int i = 0; i < 20; i++) begin
      rd_req  = 1'b1;
      rd_addr = 4'(i * 7);
      dimmer  = 2'(i);
      @(negedge clk);
    end
    rd_req = 1'b0;
    rot_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset with a read sitting in stage 1.
    rd_req  = 1'b1;
    rd_addr = 4'd1;
    @(negedge clk);
    rd_req = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("flush_valid", 32'(rd_valid), 32'd0);
    check("flush_offset", 32'(rot_offset), 32'd0);
    count_busy("busy_after_flush");

    // Reset again partway through reload, with read and write requests held.
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 4'd2;
    dimmer  = 2'd0;
    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_data = 24'hFFFFFF;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    count_busy("busy_after_midreload");
    rd_req = 1'b0;
    wr_en  = 1'b0;
    repeat (3) @(negedge clk);
    read_lit("rd2_dropped_wr", 2, 0, 24'h99CC00);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
